operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_if.sv | 64 ++++++
 rtl/operand_fetch.sv | 131 +++++++++++++
 tb/tb_operand_fetch.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Handshake and bus bundle for the operand_fetch stage: decoded-instruction
// input, register-file read port, writeback bus, flush and execute output.
// slave = operand_fetch side, master = surrounding pipeline / register file.
`ifndef WORDSZ
`define WORDSZ 32
`endif
`ifndef REGADDRSZ
`define REGADDRSZ 5
`endif

interface operand_fetch_if #(
    parameter int WORDSZ    = `WORDSZ,
    parameter int REGADDRSZ = `REGADDRSZ
);
    // Decoded instruction from decode
    logic                 in_valid;
    logic                 in_ready;
    logic [WORDSZ-1:0]    in_pc;
    logic [REGADDRSZ-1:0] in_rs1_addr;
    logic [REGADDRSZ-1:0] in_rs2_addr;
    logic [REGADDRSZ-1:0] in_rd_addr;
    logic                 in_rd_wen;
    // Combinational register-file read port
    logic [REGADDRSZ-1:0] rs1_addr;
    logic [REGADDRSZ-1:0] rs2_addr;
    logic [WORDSZ-1:0]    rs1_val;
    logic [WORDSZ-1:0]    rs2_val;
    // Writeback bus (same as the register-file write port)
    logic                 wb_en;
    logic [REGADDRSZ-1:0] wb_addr;
    logic [WORDSZ-1:0]    wb_val;
    // Pipeline control
    logic                 flush;
    // Instruction with operands to execute
    logic                 out_valid;
    logic                 out_ready;
    logic [WORDSZ-1:0]    out_pc;
    logic [WORDSZ-1:0]    out_rs1_val;
    logic [WORDSZ-1:0]    out_rs2_val;
    logic [REGADDRSZ-1:0] out_rd_addr;
    logic                 out_rd_wen;

    modport slave (
        input  in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rd_wen,
        output in_ready,
        output rs1_addr, rs2_addr,
        input  rs1_val, rs2_val,
        input  wb_en, wb_addr, wb_val,
        input  flush,
        input  out_ready,
        output out_valid, out_pc, out_rs1_val, out_rs2_val, out_rd_addr, out_rd_wen
    );

    modport master (
        output in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rd_wen,
        input  in_ready,
        input  rs1_addr, rs2_addr,
        output rs1_val, rs2_val,
        output wb_en, wb_addr, wb_val,
        output flush,
        output out_ready,
        input  out_valid, out_pc, out_rs1_val, out_rs2_val, out_rd_addr, out_rd_wen
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads both source registers, tracks in-flight
// destination registers in a pending scoreboard, stalls on RAW/WAW hazards
// and registers the instruction plus operands for execute (1-cycle latency).
// Optional macro OPERAND_FETCH_BYPASS_EN forwards the writeback value into the
// operands and releases the hazard in the writeback cycle itself.
`ifndef WORDSZ
`define WORDSZ 32
`endif
`ifndef REGADDRSZ
`define REGADDRSZ 5
`endif

module operand_fetch #(
    parameter int WORDSZ    = `WORDSZ,
    parameter int REGADDRSZ = `REGADDRSZ
) (
    input logic             clk,
    input logic             reset,
    operand_fetch_if.slave  bus
);
    localparam int NREGS = 2 ** REGADDRSZ;

    logic [NREGS-1:0]     r_pending;
    logic                 r_out_valid;
    logic [WORDSZ-1:0]    r_out_pc;
    logic [WORDSZ-1:0]    r_out_rs1_val;
    logic [WORDSZ-1:0]    r_out_rs2_val;
    logic [REGADDRSZ-1:0] r_out_rd_addr;
    logic                 r_out_rd_wen;

    logic [NREGS-1:0]     w_wb_rel;
    logic [NREGS-1:0]     w_flush_rel;
    logic [NREGS-1:0]     w_set;
    logic [NREGS-1:0]     w_hz_mask;
    logic                 w_flush_clr;
    logic                 w_hazard;
    logic                 w_in_ready;
    logic                 w_issue;
    logic [WORDSZ-1:0]    w_rs1_op;
    logic [WORDSZ-1:0]    w_rs2_op;

    assign bus.rs1_addr = bus.in_rs1_addr;
    assign bus.rs2_addr = bus.in_rs2_addr;

    // A flushed instruction that execute did not take this cycle never writes
    // back, so its scoreboard bit must be dropped here.
    assign w_flush_clr = bus.flush && r_out_valid && !bus.out_ready &&
                         r_out_rd_wen && (r_out_rd_addr != '0);

    // Per-register release (writeback, flush) and set (issue) vectors
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_wb_rel    = '0;
        w_flush_rel = '0;
        w_set       = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_wb_rel[i]    = bus.wb_en && (bus.wb_addr == REGADDRSZ'(i));
            w_flush_rel[i] = w_flush_clr && (r_out_rd_addr == REGADDRSZ'(i));
            w_set[i]       = w_issue && bus.in_rd_wen && (bus.in_rd_addr == REGADDRSZ'(i));
        end
    end

`ifdef OPERAND_FETCH_BYPASS_EN
    // Writeback releases its register in the same cycle and forwards its value.
    assign w_hz_mask = r_pending & ~w_wb_rel;
    assign w_rs1_op  = (bus.wb_en && bus.wb_addr == bus.in_rs1_addr && bus.in_rs1_addr != '0)
                       ? bus.wb_val : bus.rs1_val;
    assign w_rs2_op  = (bus.wb_en && bus.wb_addr == bus.in_rs2_addr && bus.in_rs2_addr != '0)
                       ? bus.wb_val : bus.rs2_val;
`else
    // Without forwarding, wait until the register file holds the value.
    assign w_hz_mask = r_pending;
    assign w_rs1_op  = bus.rs1_val;
    assign w_rs2_op  = bus.rs2_val;
`endif

    // Hazard: a source or the destination is still owned by an older instruction
    always_comb begin
        w_hazard = 1'b0;
        if (bus.in_valid) begin
            if (bus.in_rs1_addr != '0 && w_hz_mask[bus.in_rs1_addr])
                w_hazard = 1'b1;
            if (bus.in_rs2_addr != '0 && w_hz_mask[bus.in_rs2_addr])
                w_hazard = 1'b1;
            if (bus.in_rd_wen && bus.in_rd_addr != '0 && w_hz_mask[bus.in_rd_addr])
                w_hazard = 1'b1;
        end
    end

    assign w_in_ready   = !w_hazard && !bus.flush && (!r_out_valid || bus.out_ready);
    assign w_issue      = bus.in_valid && w_in_ready;
    assign bus.in_ready = w_in_ready;

    // Scoreboard update: releases first, then a new writer's set wins
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: async reset clears every state bit; the scoreboard is a flop vector, not a RAM.
        if (!reset)
            r_pending <= '0;
        else
            // NOTE: sequential state uses non-blocking assignments to avoid simulation races.
            r_pending <= ((r_pending & ~w_wb_rel & ~w_flush_rel) | w_set) & ~NREGS'(1);
    end

    // Output register: capture on issue, hold while stalled, drop on take or flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid   <= 1'b0;
            r_out_pc      <= '0;
            r_out_rs1_val <= '0;
            r_out_rs2_val <= '0;
            r_out_rd_addr <= '0;
            r_out_rd_wen  <= 1'b0;
        end else if (w_issue) begin
            r_out_valid   <= 1'b1;
            r_out_pc      <= bus.in_pc;
            r_out_rs1_val <= w_rs1_op;
            r_out_rs2_val <= w_rs2_op;
            r_out_rd_addr <= bus.in_rd_addr;
            r_out_rd_wen  <= bus.in_rd_wen;
        end else if (bus.flush || bus.out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_pc      = r_out_pc;
    assign bus.out_rs1_val = r_out_rs1_val;
    assign bus.out_rs2_val = r_out_rs2_val;
    assign bus.out_rd_addr = r_out_rd_addr;
    assign bus.out_rd_wen  = r_out_rd_wen;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: hazard stall/release, output backpressure,
// flush, x0 handling, same-cycle set/clear and asynchronous reset. Register
// file model holds 0x1000+i after reset; x0 always reads 0.
module tb_operand_fetch;
    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    operand_fetch_if #(.WORDSZ(32), .REGADDRSZ(5)) bus ();

    operand_fetch #(.WORDSZ(32), .REGADDRSZ(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model
    logic [31:0] regs [32];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h1000 + 32'(i);
        end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
            regs[bus.wb_addr] <= bus.wb_val;
        end
    end
    assign bus.rs1_val = (bus.rs1_addr == 5'd0) ? 32'd0 : regs[bus.rs1_addr];
    assign bus.rs2_val = (bus.rs2_addr == 5'd0) ? 32'd0 : regs[bus.rs2_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] rd, input logic wen);
        bus.in_valid    = v;
        bus.in_pc       = pc;
        bus.in_rs1_addr = a1;
        bus.in_rs2_addr = a2;
        bus.in_rd_addr  = rd;
        bus.in_rd_wen   = wen;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] v);
        bus.wb_en   = en;
        bus.wb_addr = a;
        bus.wb_val  = v;
    endtask

    initial begin
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        wb(1'b0, 5'd0, 32'd0);

        // Reset state
        #1 reset = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_pc", bus.out_pc, 0);
        check("rst_out_rd", {bus.out_rd_addr, bus.out_rd_wen}, 0);
        check("rst_pending", dut.r_pending, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        step();

        // RAW hazard on x5, released by writeback
        drive(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 1'b1);
        #1 check("a_ready0", bus.in_ready, 1);
        step();
        check("a_valid0", bus.out_valid, 1);
        check("a_pc0", bus.out_pc, 32'h100);
        check("a_ops0", {bus.out_rs1_val, bus.out_rs2_val}, {32'h1001, 32'h1002});
        check("a_rd0", {bus.out_rd_addr, bus.out_rd_wen}, {5'd5, 1'b1});
        drive(1'b1, 32'h104, 5'd5, 5'd0, 5'd6, 1'b0);
        #1 check("a_stall", bus.in_ready, 0);
        step();
        check("a_drained", bus.out_valid, 0);
        wb(1'b1, 5'd5, 32'h1234);
`ifdef OPERAND_FETCH_BYPASS_EN
        #1 check("a_wb_ready", bus.in_ready, 1);
        step();
        wb(1'b0, 5'd0, 32'd0);
        drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
`else
        #1 check("a_wb_ready", bus.in_ready, 0);
        step();
        wb(1'b0, 5'd0, 32'd0);
        check("a_wb_no_issue", bus.out_valid, 0);
        #1 check("a_rel_ready", bus.in_ready, 1);
        step();
        drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
`endif
        check("a_valid1", bus.out_valid, 1);
        check("a_pc1", bus.out_pc, 32'h104);
        check("a_rs1_fwd", bus.out_rs1_val, 32'h1234);
        step();
        check("a_idle", bus.out_valid, 0);

        // Backpressure: hold for 3 cycles, then next instruction issues
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h200, 5'd3, 5'd4, 5'd8, 1'b1);
        step();
        check("b_valid", bus.out_valid, 1);
        drive(1'b1, 32'h204, 5'd1, 5'd2, 5'd10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1 check("b_hold_ready", bus.in_ready, 0);
            step();
            check("b_hold_out", {bus.out_valid, bus.out_pc, bus.out_rs1_val, bus.out_rs2_val, bus.out_rd_addr},
                  {1'b1, 32'h200, 32'h1003, 32'h1004, 5'd8});
        end
        bus.out_ready = 1'b1;
        #1 check("b_release_ready", bus.in_ready, 1);
        step();
        check("b_next", {bus.out_valid, bus.out_pc, bus.out_rd_addr}, {1'b1, 32'h204, 5'd10});
        drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();

        // Flush of a held writer on x7
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h300, 5'd1, 5'd2, 5'd7, 1'b1);
        step();
        check("c_pend7_set", dut.r_pending[7], 1);
        drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        bus.flush = 1'b1;
        #1 check("c_flush_ready", bus.in_ready, 0);
        step();
        bus.flush = 1'b0;
        check("c_flushed", bus.out_valid, 0);
        check("c_pend7_clr", dut.r_pending[7], 0);
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h304, 5'd7, 5'd0, 5'd0, 1'b0);
        #1 check("c_x7_ready", bus.in_ready, 1);
        step();
        check("c_x7_op", {bus.out_valid, bus.out_rs1_val}, {1'b1, 32'h1007});

        // x0 destination and source never stall, never forwarded
        drive(1'b1, 32'h400, 5'd0, 5'd0, 5'd0, 1'b1);
        #1 check("d_ready0", bus.in_ready, 1);
        step();
        check("d_op0", {bus.out_pc, bus.out_rs1_val}, {32'h400, 32'h0});
        drive(1'b1, 32'h404, 5'd0, 5'd0, 5'd0, 1'b1);
        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        #1 check("d_ready1", bus.in_ready, 1);
        step();
        wb(1'b0, 5'd0, 32'd0);
        check("d_op1", {bus.out_pc, bus.out_rs1_val, bus.out_rs2_val}, {32'h404, 32'h0, 32'h0});
        check("d_pend0", dut.r_pending[0], 0);

        // Same-cycle writeback and new writer on x9: set wins
        drive(1'b1, 32'h500, 5'd1, 5'd2, 5'd9, 1'b1);
        wb(1'b1, 5'd9, 32'h99);
        #1 check("e_ready", bus.in_ready, 1);
        step();
        wb(1'b0, 5'd0, 32'd0);
        check("e_pend9", dut.r_pending[9], 1);
        drive(1'b1, 32'h504, 5'd1, 5'd9, 5'd0, 1'b0);
        #1 check("e_stall", bus.in_ready, 0);
        step();
        check("e_drained", bus.out_valid, 0);
        wb(1'b1, 5'd9, 32'hAB);
`ifdef OPERAND_FETCH_BYPASS_EN
        step();
        wb(1'b0, 5'd0, 32'd0);
`else
        step();
        wb(1'b0, 5'd0, 32'd0);
        step();
`endif
        drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("e_issue", {bus.out_valid, bus.out_pc, bus.out_rs2_val}, {1'b1, 32'h504, 32'hAB});
        step();

        // Asynchronous reset mid-stream
        drive(1'b1, 32'h600, 5'd1, 5'd2, 5'd11, 1'b1);
        step();
        check("f_valid", bus.out_valid, 1);
        drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1 reset = 1'b0;
        #1;
        check("f_rst_valid", bus.out_valid, 0);
        check("f_rst_pending", dut.r_pending, 0);
        check("f_rst_out", {bus.out_pc, bus.out_rs1_val, bus.out_rs2_val, bus.out_rd_addr, bus.out_rd_wen}, 0);
        #1 reset = 1'b1;
        step();
        check("f_after", bus.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
